// File: rtl/dbg_cmd_decoder.sv
// dbg_cmd_decoder: byte-level debug command parser.
// Parses 'W' addr data (write, answers 'K') and 'R' addr (read, answers with
// the register value). Any other first byte is answered with '?'.
// Exactly one response byte is returned per command.
// Optional feature macro: DBG_TIMEOUT_EN enables an inactivity timeout that
// abandons a half-received command. Without it, timeout is tied low.
module dbg_cmd_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_BITS  = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [REG_ADDR_BITS-1:0] addr_read,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic [REG_ADDR_BITS-1:0] addr_write,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_enable,
    output logic                     rx_drop,
    output logic                     timeout
);

    // Address bytes are truncated to REG_ADDR_BITS, so the address cannot be
    // wider than a byte; the command/response bytes assume an 8-bit UART.
    if (DATA_WIDTH != 8 || REG_ADDR_BITS > DATA_WIDTH || REG_ADDR_BITS < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dbg_cmd_decoder: unsupported parameter set");
    end

    localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'h57); // 'W'
    localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'h52); // 'R'
    localparam logic [DATA_WIDTH-1:0] RSP_ACK  = DATA_WIDTH'(8'h4B); // 'K'
    localparam logic [DATA_WIDTH-1:0] RSP_UNK  = DATA_WIDTH'(8'h3F); // '?'

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_DO_WRITE,
        S_DO_READ,
        S_SEND
    } state_e;

    state_e                   state_q, state_d;
    logic                     is_write_q, is_write_d;
    logic [REG_ADDR_BITS-1:0] addr_read_q, addr_read_d;
    logic [REG_ADDR_BITS-1:0] addr_write_q, addr_write_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                     rx_drop_q, rx_drop_d;

`ifdef DBG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_q, timeout_d;

    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    // Next-state and datapath decode; every register holds unless a state acts.
    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        addr_read_d  = addr_read_q;
        addr_write_d = addr_write_q;
        write_data_d = write_data_q;
        tx_data_d    = tx_data_q;
        rx_drop_d    = 1'b0;
`ifdef DBG_TIMEOUT_EN
        cnt_d        = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_write_d = (rx_data == OP_WRITE);
                        state_d    = S_GET_ADDR;
                    end else begin
                        tx_data_d = RSP_UNK;
                        state_d   = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    if (is_write_q) begin
                        addr_write_d = rx_data[REG_ADDR_BITS-1:0];
                        state_d      = S_GET_DATA;
                    end else begin
                        addr_read_d = rx_data[REG_ADDR_BITS-1:0];
                        state_d     = S_DO_READ;
                    end
                end
            end
            S_GET_DATA: begin
                if (rx_valid) begin
                    write_data_d = rx_data;
                    state_d      = S_DO_WRITE;
                end
            end
            S_DO_WRITE: begin
                // write_enable is decoded from this state, so it lasts one cycle.
                tx_data_d = RSP_ACK;
                rx_drop_d = rx_valid;
                state_d   = S_SEND;
            end
            S_DO_READ: begin
                // read_data is combinational from addr_read, registered here.
                tx_data_d = read_data;
                rx_drop_d = rx_valid;
                state_d   = S_SEND;
            end
            S_SEND: begin
                // A byte on the acceptance edge is still dropped: the parser is
                // only listening again from the following cycle.
                rx_drop_d = rx_valid;
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DBG_TIMEOUT_EN
        // Count silent cycles mid-command; a byte on the expiry edge wins.
        if ((state_q == S_GET_ADDR || state_q == S_GET_DATA) && !rx_valid) begin
            if (cnt_inc == CNT_MAX) begin
                state_d   = S_IDLE;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
`endif
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            is_write_q   <= 1'b0;
            addr_read_q  <= '0;
            addr_write_q <= '0;
            write_data_q <= '0;
            tx_data_q    <= '0;
            rx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            addr_read_q  <= addr_read_d;
            addr_write_q <= addr_write_d;
            write_data_q <= write_data_d;
            tx_data_q    <= tx_data_d;
            rx_drop_q    <= rx_drop_d;
        end
    end

`ifdef DBG_TIMEOUT_EN
    // Inactivity counter and its one-cycle expiry pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Strobes are state decodes so reset removes them immediately.
    assign write_enable = (state_q == S_DO_WRITE);
    assign tx_valid     = (state_q == S_SEND);
    assign tx_data      = tx_data_q;
    assign addr_read    = addr_read_q;
    assign addr_write   = addr_write_q;
    assign write_data   = write_data_q;
    assign rx_drop      = rx_drop_q;

endmodule

// File: tb/tb_dbg_cmd_decoder.sv
// Directed bench for dbg_cmd_decoder with a register-file model and a
// scoreboard of expected writes and response bytes.
module tb_dbg_cmd_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] addr_read;
    logic [7:0] read_data;
    logic [7:0] addr_write;
    logic [7:0] write_data;
    logic       write_enable;
    logic       rx_drop;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic [7:0]  rsp_q [$];
    logic [15:0] wr_q  [$];

    always #5 clk = ~clk;

    dbg_cmd_decoder #(
        .DATA_WIDTH     (8),
        .REG_ADDR_BITS  (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .addr_read    (addr_read),
        .read_data    (read_data),
        .addr_write   (addr_write),
        .write_data   (write_data),
        .write_enable (write_enable),
        .rx_drop      (rx_drop),
        .timeout      (timeout)
    );

    // Register file model: address 0 ignores writes.
    assign read_data = mem[addr_read];
    always @(posedge clk) begin
        if (write_enable && addr_write != 8'h00) mem[addr_write] <= write_data;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop expected writes and responses as the DUT produces them.
    always @(negedge clk) begin
        logic [15:0] w;
        if (!rst) begin
            if (write_enable) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {15'd0, write_enable}, 16'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", {8'd0, addr_write}, {8'd0, w[15:8]});
                    chk("wr_data", {8'd0, write_data}, {8'd0, w[7:0]});
                end
            end
            if (tx_valid && tx_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {15'd0, tx_valid}, 16'd0);
                end else begin
                    chk("rsp_byte", {8'd0, tx_data}, {8'd0, rsp_q.pop_front()});
                end
            end
            if (timeout) to_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wr_cmd(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        rsp_q.push_back(8'h4B);
        if (a != 8'h00) exp_mem[a] = d;
        send_byte(8'h57);
        send_byte(a);
        send_byte(d);
    endtask

    task automatic rd_cmd(input logic [7:0] a);
        rsp_q.push_back(exp_mem[a]);
        send_byte(8'h52);
        send_byte(a);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (rsp_q.size() + wr_q.size()) != 0; i++) tick();
        chk(tag, 16'(rsp_q.size() + wr_q.size()), 16'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h01] = 8'h11;
        mem[8'h03] = 8'h33;
        mem[8'h10] = 8'h5C;
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        chk("rst_we", {15'd0, write_enable}, 16'd0);
        chk("rst_rx_drop", {15'd0, rx_drop}, 16'd0);
        chk("rst_timeout", {15'd0, timeout}, 16'd0);
        chk("rst_tx_data", {8'd0, tx_data}, 16'd0);
        chk("rst_addr_read", {8'd0, addr_read}, 16'd0);
        chk("rst_addr_write", {8'd0, addr_write}, 16'd0);
        chk("rst_write_data", {8'd0, write_data}, 16'd0);
        rst = 1'b0;
        tick();

        // Write 0x05 <= 0xA5 with latency checks
        wr_q.push_back({8'h05, 8'hA5});
        rsp_q.push_back(8'h4B);
        exp_mem[8'h05] = 8'hA5;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'hA5);
        chk("wr_we_k1", {15'd0, write_enable}, 16'd1);
        chk("wr_txv_k1", {15'd0, tx_valid}, 16'd0);
        tick();
        chk("wr_we_k2", {15'd0, write_enable}, 16'd0);
        chk("wr_txv_k2", {15'd0, tx_valid}, 16'd1);
        chk("wr_ack", {8'd0, tx_data}, 16'h004B);
        drain("wr05_drain");

        // Read 0x05 with latency checks
        rsp_q.push_back(exp_mem[8'h05]);
        send_byte(8'h52);
        send_byte(8'h05);
        chk("rd_txv_k1", {15'd0, tx_valid}, 16'd0);
        chk("rd_addr", {8'd0, addr_read}, 16'h0005);
        tick();
        chk("rd_txv_k2", {15'd0, tx_valid}, 16'd1);
        chk("rd_data", {8'd0, tx_data}, 16'h00A5);
        drain("rd05_drain");

        // Address 0 write is acknowledged, read returns zero
        wr_cmd(8'h00, 8'hFF);
        drain("wr00_drain");
        rd_cmd(8'h00);
        drain("rd00_drain");

        // Unknown opcode held under back-pressure
        tx_ready = 1'b0;
        rsp_q.push_back(8'h3F);
        send_byte(8'h41);
        for (int i = 0; i < 10; i++) begin
            chk("hold_txv", {15'd0, tx_valid}, 16'd1);
            chk("hold_txd", {8'd0, tx_data}, 16'h003F);
            chk("hold_we", {15'd0, write_enable}, 16'd0);
            tick();
        end
        tx_ready = 1'b1;
        drain("unk_drain");

        // Lower-case opcode is unknown; address registers hold
        rsp_q.push_back(8'h3F);
        send_byte(8'h77);
        drain("lower_drain");
        chk("addr_write_hold", {8'd0, addr_write}, 16'h0000);
        chk("write_data_hold", {8'd0, write_data}, 16'h00FF);

        // Byte during SEND is dropped, response unaffected
        tx_ready = 1'b0;
        rsp_q.push_back(exp_mem[8'h10]);
        send_byte(8'h52);
        send_byte(8'h10);
        tick();
        send_byte(8'h33);
        chk("drop_pulse", {15'd0, rx_drop}, 16'd1);
        tick();
        chk("drop_end", {15'd0, rx_drop}, 16'd0);
        tx_ready = 1'b1;
        drain("drop_drain");

        // Byte on the acceptance edge is dropped, not parsed
        rsp_q.push_back(8'h3F);
        send_byte(8'h41);
        send_byte(8'h44);
        chk("acc_drop", {15'd0, rx_drop}, 16'd1);
        chk("acc_txv", {15'd0, tx_valid}, 16'd0);
        repeat (5) tick();
        chk("acc_none", 16'(rsp_q.size()), 16'd0);
        chk("acc_idle", {15'd0, tx_valid}, 16'd0);

        // Back-to-back random writes then reads
        for (int i = 0; i < 6; i++) begin
            wr_cmd(8'(8'h20 + i), 8'($urandom_range(0, 255)));
            drain("b2b_wr");
        end
        for (int i = 0; i < 6; i++) begin
            rd_cmd(8'(8'h20 + i));
            drain("b2b_rd");
        end

`ifdef DBG_TIMEOUT_EN
        // Partial command abandoned after TO silent cycles
        to_pulses = 0;
        send_byte(8'h57);
        send_byte(8'h03);
        repeat (TO - 1) tick();
        chk("to_early", {15'd0, timeout}, 16'd0);
        tick();
        chk("to_pulse", {15'd0, timeout}, 16'd1);
        tick();
        chk("to_end", {15'd0, timeout}, 16'd0);
        chk("to_count", 16'(to_pulses), 16'd1);
        chk("to_no_txv", {15'd0, tx_valid}, 16'd0);
        rd_cmd(8'h03);
        drain("to_rd_drain");
`else
        // Without the timeout the parser waits for the data byte
        to_pulses = 0;
        send_byte(8'h57);
        send_byte(8'h03);
        repeat (40) tick();
        chk("noto_timeout", {15'd0, timeout}, 16'd0);
        chk("noto_count", 16'(to_pulses), 16'd0);
        chk("noto_txv", {15'd0, tx_valid}, 16'd0);
        wr_q.push_back({8'h03, 8'h3C});
        rsp_q.push_back(8'h4B);
        exp_mem[8'h03] = 8'h3C;
        send_byte(8'h3C);
        drain("noto_wr_drain");
        rd_cmd(8'h03);
        drain("noto_rd_drain");
`endif

        // Reset during DO_WRITE kills the strobe at once
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h77);
        chk("rstw_we_pre", {15'd0, write_enable}, 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstw_we", {15'd0, write_enable}, 16'd0);
        chk("rstw_txv", {15'd0, tx_valid}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset during SEND drops tx_valid without a handshake
        tx_ready = 1'b0;
        send_byte(8'h41);
        chk("rsts_txv_pre", {15'd0, tx_valid}, 16'd1);
        #1 rst = 1'b1;
        #1;
        chk("rsts_txv", {15'd0, tx_valid}, 16'd0);
        chk("rsts_txd", {8'd0, tx_data}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tx_ready = 1'b1;
        tick();

        // Aborted write left register 1 untouched
        rd_cmd(8'h01);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
